// File: rtl/uart_pkg.sv
// Shared types and byte constants for the UART loopback line path.
package uart_pkg;

    typedef enum logic {FILL, DRAIN} line_state_t;

    localparam logic [7:0] UART_CR = 8'h0D;
    localparam logic [7:0] UART_LF = 8'h0A;

endpackage

// File: rtl/uart_line_buffer_if.sv
// RX strobe, TX handshake and status bundle of the line buffer.
interface uart_line_buffer_if #(
    parameter int CNT_W = 16
);
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, busy, overflow, drop_cnt
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, busy, overflow, drop_cnt
    );
endinterface

// File: rtl/uart_byte_ram.sv
// DEPTH x 8 line storage: one synchronous write port, one asynchronous read port.
module uart_byte_ram #(
    parameter int DEPTH = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_line_buffer.sv
// Collects an RX line up to the terminator (or a full buffer), then replays it to TX.
// Bytes arriving during replay are dropped and counted.
module uart_line_buffer
    import uart_pkg::*;
#(
    parameter int         DEPTH = 64,
    parameter logic [7:0] TERM  = UART_CR,
    parameter int         CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    uart_line_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    line_state_t       state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [CNT_W-1:0]  drop_cnt;
    logic              overflow;
    logic              wr_en, pop, drop;
    logic [7:0]        rd_data;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        case (state)
            FILL: begin
                if (bus.rx_valid) begin
                    wr_en = 1'b1;
                    // one check covers both closers, so TERM landing in the last slot triggers once
                    if (bus.rx_data == TERM || count + 1'b1 == CNT_FULL) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                drop = bus.rx_valid;
                if (count != '0 && bus.tx_ready) begin
                    pop = 1'b1;
                    if (count == CNT_ONE) state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            overflow <= drop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    uart_byte_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.rx_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign bus.tx_valid = (state == DRAIN) && (count != '0);
    assign bus.tx_data  = rd_data;
    assign bus.busy     = (state == DRAIN);
    assign bus.overflow = overflow;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: queue model checked every cycle plus directed literal checks.
module tb_uart_line_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_line_buffer_if #(.CNT_W(16)) bus_a ();
    uart_line_buffer_if #(.CNT_W(4))  bus_b ();

    uart_line_buffer #(.DEPTH(64), .TERM(8'h0D), .CNT_W(16)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    uart_line_buffer #(.DEPTH(64), .TERM(8'h0D), .CNT_W(4)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    assign bus_b.rx_valid = bus_a.rx_valid;
    assign bus_b.rx_data  = bus_a.rx_data;
    assign bus_b.tx_ready = bus_a.tx_ready;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a line is a queue of bytes, the buffer is either filling or replaying.
    logic [7:0] q [$];
    bit         m_drain = 0;
    bit         m_ovf   = 0;
    int         m_drops = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_drain = 0;
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            m_ovf = 0;
            if (!m_drain) begin
                if (bus_a.rx_valid) begin
                    q.push_back(bus_a.rx_data);
                    if (bus_a.rx_data == 8'h0D || q.size() == 64) m_drain = 1;
                end
            end else begin
                if (bus_a.rx_valid) begin
                    m_ovf = 1;
                    m_drops++;
                end
                if (bus_a.tx_ready && q.size() > 0) void'(q.pop_front());
                if (q.size() == 0) m_drain = 0;
            end
        end
    end

    logic [7:0] log_q [$];
    int busy_cyc = 0;
    int ovf_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            logic exp_valid;
            int   exp_a, exp_b;
            exp_valid = m_drain && (q.size() > 0);
            exp_a = (m_drops > 65535) ? 65535 : m_drops;
            exp_b = (m_drops > 15) ? 15 : m_drops;
            check("tx_valid_a", bus_a.tx_valid, exp_valid);
            check("tx_valid_b", bus_b.tx_valid, exp_valid);
            if (exp_valid) begin
                check("tx_data_a", bus_a.tx_data, q[0]);
                check("tx_data_b", bus_b.tx_data, q[0]);
            end
            check("busy_a", bus_a.busy, m_drain);
            check("busy_b", bus_b.busy, m_drain);
            check("overflow_a", bus_a.overflow, m_ovf);
            check("overflow_b", bus_b.overflow, m_ovf);
            check("drop_cnt_a", bus_a.drop_cnt, exp_a);
            check("drop_cnt_b", bus_b.drop_cnt, exp_b);
            if (bus_a.tx_valid && bus_a.tx_ready) log_q.push_back(bus_a.tx_data);
            if (bus_a.busy) busy_cyc++;
            if (bus_a.overflow) ovf_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_a.rx_valid = 1'b1;
        bus_a.rx_data  = b;
        tick();
        bus_a.rx_valid = 1'b0;
    endtask

    task automatic wait_fill(input int budget);
        int n = 0;
        while (bus_a.busy && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", bus_a.busy, 0);
    endtask

    task automatic start_line;
        log_q.delete();
        busy_cyc = 0;
        ovf_cnt  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat [4];
        bus_a.rx_valid = 1'b0;
        bus_a.rx_data  = 8'h00;
        bus_a.tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid", bus_a.tx_valid, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_overflow", bus_a.overflow, 0);
        check("rst_drop_cnt", bus_a.drop_cnt, 0);
        rst = 1'b0;
        tick();

        // basic line
        start_line();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
        check("basic_busy_next", bus_a.busy, 1);
        check("basic_first", bus_a.tx_data, 8'h41);
        wait_fill(20);
        check("basic_len", log_q.size(), 3);
        pat = '{8'h41, 8'h42, 8'h0D, 8'h00};
        for (int i = 0; i < 3 && i < log_q.size(); i++) check("basic_byte", log_q[i], pat[i]);
        check("basic_busy_cyc", busy_cyc, 3);

        // backpressure 1-0-0-1
        start_line();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
        pat = '{8'h01, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) begin
            bus_a.tx_ready = pat[i][0];
            tick();
        end
        bus_a.tx_ready = 1'b1;
        wait_fill(20);
        check("bp_len", log_q.size(), 3);
        pat = '{8'h41, 8'h42, 8'h0D, 8'h00};
        for (int i = 0; i < 3 && i < log_q.size(); i++) check("bp_byte", log_q[i], pat[i]);
        check("bp_busy_cyc", busy_cyc, 5);

        // full without terminator; pattern avoids 0x0D so only the full condition closes the line
        start_line();
        for (int i = 0; i < 63; i++) send_byte(8'(8'h40 + i));
        check("full_not_yet", bus_a.busy, 0);
        send_byte(8'h7F);
        check("full_drain", bus_a.busy, 1);
        wait_fill(200);
        check("full_len", log_q.size(), 64);
        for (int i = 0; i < 64 && i < log_q.size(); i++) check("full_byte", log_q[i], 8'(8'h40 + i));

        // terminator as the 64th byte: one line of 64, one drain
        start_line();
        for (int i = 0; i < 63; i++) send_byte(8'(8'h40 + i));
        send_byte(8'h0D);
        wait_fill(200);
        check("term64_len", log_q.size(), 64);
        if (log_q.size() == 64) check("term64_last", log_q[63], 8'h0D);
        check("term64_busy_cyc", busy_cyc, 64);
        tick();
        check("term64_idle", bus_a.busy, 0);

        // drops during drain
        start_line();
        bus_a.tx_ready = 1'b0;
        send_byte(8'h58); send_byte(8'h0D);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        bus_a.tx_ready = 1'b1;
        wait_fill(20);
        check("drop_cnt3", bus_a.drop_cnt, 3);
        check("drop_pulses", ovf_cnt, 3);
        start_line();
        send_byte(8'h51); send_byte(8'h0D);
        wait_fill(20);
        check("after_drop_len", log_q.size(), 2);
        if (log_q.size() == 2) check("after_drop_b0", log_q[0], 8'h51);

        // rx on the final pop
        start_line();
        send_byte(8'h5A); send_byte(8'h0D);
        tick();
        send_byte(8'h77);
        check("simul_fill", bus_a.busy, 0);
        check("simul_drop_cnt", bus_a.drop_cnt, 4);
        check("simul_len", log_q.size(), 2);

        // reset mid-drain
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
        tick();
        check("mid_valid", bus_a.tx_valid, 1);
        check("mid_data", bus_a.tx_data, 8'h42);
        rst = 1'b1;
        #1;
        check("rst_now_valid", bus_a.tx_valid, 0);
        check("rst_now_busy", bus_a.busy, 0);
        check("rst_now_drop", bus_a.drop_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        start_line();
        send_byte(8'h4D); send_byte(8'h0D);
        wait_fill(20);
        check("post_rst_len", log_q.size(), 2);
        if (log_q.size() == 2) check("post_rst_b0", log_q[0], 8'h4D);

        // saturation of the 4-bit counter
        bus_a.tx_ready = 1'b0;
        send_byte(8'h53); send_byte(8'h0D);
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        check("sat_a", bus_a.drop_cnt, 20);
        check("sat_b", bus_b.drop_cnt, 4'hF);
        bus_a.tx_ready = 1'b1;
        wait_fill(20);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
